// File: rtl/mips32_run_ctrl.sv
// mips32_run_ctrl
// Sequencer that prepares and runs a small MIPS32 core: clears the register
// file, streams a program into instruction memory, pulses the core's init,
// then lets it run until it halts or a cycle limit expires.
//
// Ports
//   clk, rst_n                        clock, synchronous active-low reset
//   start                             begin a clear/load/run sequence
//   prog_valid/prog_data/prog_last    program word stream (ready/valid)
//   prog_ready                        controller accepts a program word
//   mem_we/mem_addr/mem_wdata         instruction-memory write port
//   reg_we/reg_addr/reg_wdata         register-file init write port
//   cpu_init                          one-cycle clear of PC / HALTED / TAKEN_BRANCH
//   cpu_run                           processor clock-enable
//   cpu_halted                        processor HALTED flag
//   busy, done, timeout, overflow     sequence status
//   cycle_count                       cycles spent in RUN (saturating)
//   words_loaded                      program words written this sequence
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start after reset
// CLR   | writing reg k = k for k = 0..31
// LOAD  | accepting program words into instruction memory
// INIT  | one-cycle cpu_init pulse
// RUN   | processor enabled, counting cycles
// DONE  | processor halted; status held until next start
// TMO   | cycle limit reached; status held until next start
module mips32_run_ctrl #(
  parameter int ADDR_W     = 10,
  parameter int MAX_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                prog_valid,
  input  logic [31:0]         prog_data,
  input  logic                prog_last,
  output logic                prog_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [31:0]         mem_wdata,
  output logic                reg_we,
  output logic [4:0]          reg_addr,
  output logic [31:0]         reg_wdata,
  output logic                cpu_init,
  output logic                cpu_run,
  input  logic                cpu_halted,
  output logic                busy,
  output logic                done,
  output logic                timeout,
  output logic                overflow,
  output logic [15:0]         cycle_count,
  output logic [ADDR_W:0]     words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_LOAD, S_INIT, S_RUN, S_DONE, S_TMO
  } state_t;

  localparam logic [ADDR_W-1:0] TOP_ADDR = '1;
  localparam logic [15:0]       LIMIT    = 16'(MAX_CYCLES - 1);
  localparam logic [15:0]       CC_SAT   = 16'hffff;
  localparam logic [ADDR_W:0]   WL_ONE   = (ADDR_W+1)'(1);

  state_t     state, state_nxt;
  logic [4:0] clr_k;
  logic       xfer;
  logic       at_top;
  logic       at_limit;

  assign xfer     = (state == S_LOAD) && prog_valid;
  assign at_top   = (words_loaded[ADDR_W-1:0] == TOP_ADDR);
  assign at_limit = (cycle_count == LIMIT);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Strobes, addresses and data are forced to zero outside the cycles that
  // use them so the outputs are fully quiet in IDLE/DONE/TMO.
  always_comb begin
    state_nxt  = state;
    prog_ready = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    reg_we     = 1'b0;
    reg_addr   = '0;
    reg_wdata  = '0;
    cpu_init   = 1'b0;
    cpu_run    = 1'b0;
    busy       = 1'b0;
    unique case (state)
      S_IDLE, S_DONE, S_TMO: begin
        if (start) state_nxt = S_CLR;
      end
      S_CLR: begin
        busy      = 1'b1;
        reg_we    = 1'b1;
        reg_addr  = clr_k;
        reg_wdata = {27'd0, clr_k};
        if (clr_k == 5'd31) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        busy       = 1'b1;
        prog_ready = 1'b1;
        if (xfer) begin
          mem_we    = 1'b1;
          mem_addr  = words_loaded[ADDR_W-1:0];
          mem_wdata = prog_data;
          // Last memory slot filled: stop loading even without prog_last.
          if (prog_last || at_top) state_nxt = S_INIT;
        end
      end
      S_INIT: begin
        busy      = 1'b1;
        cpu_init  = 1'b1;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        busy    = 1'b1;
        cpu_run = 1'b1;
        // Halt has priority over the cycle limit.
        if (cpu_halted)    state_nxt = S_DONE;
        else if (at_limit) state_nxt = S_TMO;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clr_k        <= '0;
      words_loaded <= '0;
      cycle_count  <= '0;
      done         <= 1'b0;
      timeout      <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE, S_TMO: begin
          if (start) begin
            clr_k        <= '0;
            words_loaded <= '0;
            cycle_count  <= '0;
            done         <= 1'b0;
            timeout      <= 1'b0;
            overflow     <= 1'b0;
          end
        end
        S_CLR: clr_k <= clr_k + 5'd1;
        S_LOAD: begin
          if (xfer) begin
            words_loaded <= words_loaded + WL_ONE;
            if (!prog_last && at_top) overflow <= 1'b1;
          end
        end
        S_RUN: begin
          // The halting cycle itself is not counted, so the count freezes.
          if (cpu_halted) begin
            done <= 1'b1;
          end else begin
            if (at_limit) timeout <= 1'b1;
            if (cycle_count != CC_SAT) cycle_count <= cycle_count + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips32_run_ctrl.sv
// Testbench for mips32_run_ctrl. Two instances: a default-width one
// (ADDR_W=10) and a tiny-memory one (ADDR_W=3), both with MAX_CYCLES=50.
// A monitor logs register/memory writes and pulses; each sequence is then
// judged against results derived directly from the stimulus.
module tb_mips32_run_ctrl;

  localparam int MAXC = 50;

  typedef struct packed {
    logic        prog_ready;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        reg_we;
    logic [4:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        cpu_init;
    logic        cpu_run;
    logic        busy;
    logic        done;
    logic        timeout;
    logic        overflow;
    logic [15:0] cycle_count;
    logic [10:0] words_loaded;
  } obs_t;

  typedef struct {
    int d; int n; int mode; bit use_last; int halt_at; bit poke;
    int e_w; int e_ovf; int e_done; int e_tmo; int e_cc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start[2];
  logic        prog_valid[2];
  logic [31:0] prog_data[2];
  logic        prog_last[2];
  logic        cpu_halted[2];

  logic        a_prog_ready, a_mem_we, a_reg_we, a_cpu_init, a_cpu_run;
  logic        a_busy, a_done, a_timeout, a_overflow;
  logic [9:0]  a_mem_addr;
  logic [31:0] a_mem_wdata, a_reg_wdata;
  logic [4:0]  a_reg_addr;
  logic [15:0] a_cycle_count;
  logic [10:0] a_words_loaded;

  logic        b_prog_ready, b_mem_we, b_reg_we, b_cpu_init, b_cpu_run;
  logic        b_busy, b_done, b_timeout, b_overflow;
  logic [2:0]  b_mem_addr;
  logic [31:0] b_mem_wdata, b_reg_wdata;
  logic [4:0]  b_reg_addr;
  logic [15:0] b_cycle_count;
  logic [3:0]  b_words_loaded;

  obs_t obs[2];

  int checks = 0;
  int failures = 0;
  int cur_d = 0;

  int reg_aq[$];
  int reg_dq[$];
  int mem_aq[$];
  logic [31:0] mem_dq[$];
  int init_cnt = 0;
  int run_cnt = 0;
  int inv_bad = 0;

  always #5 clk = ~clk;

  mips32_run_ctrl #(.ADDR_W(10), .MAX_CYCLES(MAXC)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start[0]),
    .prog_valid(prog_valid[0]), .prog_data(prog_data[0]), .prog_last(prog_last[0]),
    .prog_ready(a_prog_ready), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .reg_we(a_reg_we), .reg_addr(a_reg_addr),
    .reg_wdata(a_reg_wdata), .cpu_init(a_cpu_init), .cpu_run(a_cpu_run),
    .cpu_halted(cpu_halted[0]), .busy(a_busy), .done(a_done),
    .timeout(a_timeout), .overflow(a_overflow), .cycle_count(a_cycle_count),
    .words_loaded(a_words_loaded)
  );

  mips32_run_ctrl #(.ADDR_W(3), .MAX_CYCLES(MAXC)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start[1]),
    .prog_valid(prog_valid[1]), .prog_data(prog_data[1]), .prog_last(prog_last[1]),
    .prog_ready(b_prog_ready), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .reg_we(b_reg_we), .reg_addr(b_reg_addr),
    .reg_wdata(b_reg_wdata), .cpu_init(b_cpu_init), .cpu_run(b_cpu_run),
    .cpu_halted(cpu_halted[1]), .busy(b_busy), .done(b_done),
    .timeout(b_timeout), .overflow(b_overflow), .cycle_count(b_cycle_count),
    .words_loaded(b_words_loaded)
  );

  assign obs[0] = {a_prog_ready, a_mem_we, a_mem_addr, a_mem_wdata, a_reg_we,
                   a_reg_addr, a_reg_wdata, a_cpu_init, a_cpu_run, a_busy,
                   a_done, a_timeout, a_overflow, a_cycle_count, a_words_loaded};
  assign obs[1] = {b_prog_ready, b_mem_we, 7'd0, b_mem_addr, b_mem_wdata, b_reg_we,
                   b_reg_addr, b_reg_wdata, b_cpu_init, b_cpu_run, b_busy,
                   b_done, b_timeout, b_overflow, b_cycle_count, 7'd0, b_words_loaded};

  // Monitor: sampled mid-cycle, after the driver has set this cycle's inputs.
  always @(negedge clk) begin
    #2;
    if (obs[cur_d].reg_we) begin
      reg_aq.push_back(int'(obs[cur_d].reg_addr));
      reg_dq.push_back(int'(obs[cur_d].reg_wdata));
    end
    if (obs[cur_d].mem_we) begin
      mem_aq.push_back(int'(obs[cur_d].mem_addr));
      mem_dq.push_back(obs[cur_d].mem_wdata);
      if (!(prog_valid[cur_d] && obs[cur_d].prog_ready)) inv_bad++;
    end
    if (obs[cur_d].busy !== (obs[cur_d].reg_we | obs[cur_d].prog_ready |
                             obs[cur_d].cpu_init | obs[cur_d].cpu_run)) inv_bad++;
    if ($countones({obs[cur_d].reg_we, obs[cur_d].prog_ready,
                    obs[cur_d].cpu_init, obs[cur_d].cpu_run}) > 1) inv_bad++;
    if (obs[cur_d].cpu_init) init_cnt++;
    if (obs[cur_d].cpu_run) run_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=expired required=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs(input int d);
    start[d]      = 1'b0;
    prog_valid[d] = 1'b0;
    prog_data[d]  = 32'd0;
    prog_last[d]  = 1'b0;
  endtask

  // Drives one sequence. mode: 0 always valid, 1 toggling valid, 2 random.
  // abort_run / abort_words assert reset at that RUN index / after that many
  // accepted words (-1 disables).
  task automatic run_seq(input string tag, input vec_t v, input int abort_run,
                         input int abort_words, output bit aborted);
    logic [31:0] words[$];
    int i, run_idx, budget, rb, mb, ib, rcb, vb, nbad, e_run;
    bit vld, tog;
    aborted = 1'b0;
    for (int k = 0; k < v.n; k++) words.push_back($urandom);
    @(negedge clk);
    cur_d = v.d;
    rb = reg_aq.size(); mb = mem_aq.size(); ib = init_cnt; rcb = run_cnt; vb = inv_bad;
    start[v.d] = 1'b1;
    i = 0; run_idx = 0; tog = 1'b1;
    for (budget = 0; budget < 600; budget++) begin
      @(negedge clk);
      if (!rst_n) begin aborted = 1'b1; break; end
      if (obs[v.d].done || obs[v.d].timeout) break;
      start[v.d] = v.poke ? 1'($urandom_range(0, 1)) : 1'b0;
      if (obs[v.d].cpu_run) begin
        if (run_idx == v.halt_at) cpu_halted[v.d] = 1'b1;
        if (run_idx == abort_run) rst_n = 1'b0;
        run_idx++;
      end
      vld = (i < v.n) && ((v.mode == 0) || (v.mode == 1 && tog) ||
                          (v.mode == 2 && $urandom_range(0, 1) == 1));
      tog = !tog;
      prog_valid[v.d] = vld;
      prog_data[v.d]  = (i < v.n) ? words[i] : 32'd0;
      prog_last[v.d]  = vld && v.use_last && (i == v.n - 1);
      if (vld && obs[v.d].prog_ready) begin
        i++;
        if (i == abort_words) rst_n = 1'b0;
      end
    end
    idle_inputs(v.d);
    chk({tag, "_seq_end"}, (budget >= 600) ? 1 : 0, 0);
    if (aborted) begin
      cpu_halted[v.d] = 1'b0;
      return;
    end
    repeat (3) @(negedge clk);
    #3;
    cpu_halted[v.d] = 1'b0;
    nbad = 0;
    for (int k = 0; k < reg_aq.size() - rb; k++)
      if (reg_aq[rb+k] != k || reg_dq[rb+k] != k) nbad++;
    chk({tag, "_reg_cnt"}, reg_aq.size() - rb, 32);
    chk({tag, "_reg_bad"}, nbad, 0);
    nbad = 0;
    for (int k = 0; k < mem_aq.size() - mb; k++)
      if (k >= v.n || mem_aq[mb+k] != k || mem_dq[mb+k] !== words[k]) nbad++;
    chk({tag, "_mem_cnt"}, mem_aq.size() - mb, v.e_w);
    chk({tag, "_mem_bad"}, nbad, 0);
    chk({tag, "_init_pulses"}, init_cnt - ib, 1);
    e_run = v.e_done ? v.e_cc + 1 : v.e_cc;
    chk({tag, "_run_cycles"}, run_cnt - rcb, e_run);
    chk({tag, "_done"}, obs[v.d].done, v.e_done);
    chk({tag, "_timeout"}, obs[v.d].timeout, v.e_tmo);
    chk({tag, "_overflow"}, obs[v.d].overflow, v.e_ovf);
    chk({tag, "_cycle_count"}, obs[v.d].cycle_count, v.e_cc);
    chk({tag, "_words_loaded"}, obs[v.d].words_loaded, v.e_w);
    chk({tag, "_quiet"}, {obs[v.d].busy, obs[v.d].cpu_run, obs[v.d].prog_ready}, 0);
    chk({tag, "_invariants"}, inv_bad - vb, 0);
  endtask

  vec_t tbl[$];
  vec_t v;
  bit ab;
  int rb, mb;

  initial begin
    for (int d = 0; d < 2; d++) begin
      idle_inputs(d);
      cpu_halted[d] = 1'b0;
    end

    // d, n, mode, last, halt, poke | writes, ovf, done, tmo, cc
    tbl.push_back('{0,  9, 0, 1, 20, 0,  9, 0, 1, 0, 20});  // normal run
    tbl.push_back('{0,  4, 1, 1,  5, 0,  4, 0, 1, 0,  5});  // toggling valid
    tbl.push_back('{0,  3, 0, 1, -1, 0,  3, 0, 0, 1, 50});  // never halts
    tbl.push_back('{1, 10, 0, 0,  3, 0,  8, 1, 1, 0,  3});  // memory overflow
    tbl.push_back('{0,  2, 0, 1, 49, 0,  2, 0, 1, 0, 49});  // halt on limit cycle
    tbl.push_back('{1,  8, 0, 1,  0, 0,  8, 0, 1, 0,  0});  // last word fills memory
    tbl.push_back('{0,  1, 2, 1, 48, 1,  1, 0, 1, 0, 48});  // start pokes ignored
    for (int r = 0; r < 6; r++) begin
      v.d = int'($urandom_range(0, 1));
      v.mode = int'($urandom_range(0, 2));
      v.poke = 1'($urandom_range(0, 1));
      v.halt_at = int'($urandom_range(0, 60));
      if (v.d == 0) begin
        v.use_last = 1'b1; v.n = int'($urandom_range(1, 12));
      end else begin
        v.use_last = 1'($urandom_range(0, 1));
        v.n = v.use_last ? int'($urandom_range(1, 8)) : int'($urandom_range(9, 12));
      end
      // Reference rules: capacity 2^ADDR_W words; overflow unless the
      // program ends (prog_last) within capacity. Halt before the limit
      // freezes the count at the halting RUN index, else timeout at MAXC.
      if (v.use_last && v.n <= ((v.d == 0) ? 1024 : 8)) begin
        v.e_w = v.n; v.e_ovf = 0;
      end else begin
        v.e_w = (v.d == 0) ? 1024 : 8; v.e_ovf = 1;
      end
      if (v.halt_at < MAXC) begin
        v.e_done = 1; v.e_tmo = 0; v.e_cc = v.halt_at;
      end else begin
        v.e_done = 0; v.e_tmo = 1; v.e_cc = MAXC;
      end
      tbl.push_back(v);
    end

    repeat (3) @(negedge clk);
    #3;
    chk("reset_a_zero", |obs[0], 0);
    chk("reset_b_zero", |obs[1], 0);
    rst_n = 1'b1;

    for (int r = 0; r < tbl.size(); r++)
      run_seq($sformatf("row%0d", r), tbl[r], -1, -1, ab);

    // Reset during RUN at index 7, then a clean normal run.
    run_seq("rst_run", tbl[0], 7, -1, ab);
    chk("rst_run_aborted", ab, 1);
    #3;
    chk("rst_run_zero", |obs[0], 0);
    rst_n = 1'b1;
    rb = reg_aq.size(); mb = mem_aq.size();
    repeat (3) @(negedge clk);
    #3;
    chk("rst_run_no_we", (reg_aq.size() - rb) + (mem_aq.size() - mb), 0);
    chk("rst_run_idle", |obs[0], 0);
    run_seq("after_rst_run", tbl[0], -1, -1, ab);

    // Reset after 3 accepted words during LOAD, then a clean normal run.
    run_seq("rst_load", tbl[0], -1, 3, ab);
    chk("rst_load_aborted", ab, 1);
    #3;
    chk("rst_load_zero", |obs[0], 0);
    rst_n = 1'b1;
    run_seq("after_rst_load", tbl[0], -1, -1, ab);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
